// File: rtl/expipe_pkg.sv
// Shared types and constants for the execution pipeline.
// The CDB result word is opaque to the queues that carry it.
package expipe_pkg;

  // Number of execution units sharing the common data bus
  localparam int unsigned EU_N = 4;

  // Reorder-buffer index width and datapath width
  localparam int unsigned ROB_IDX_W = 6;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned EXC_W     = 5;

  // Default depth for each EU result staging buffer
  localparam int unsigned EU_RES_BUF_DEPTH = 4;

  // Completed result broadcast on the CDB
  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [XLEN-1:0]      value;
    logic                 exc_valid;
    logic [EXC_W-1:0]     exc_cause;
  } cdb_data_t;

endpackage : expipe_pkg

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and full/empty control for a power-of-two circular
// buffer whose storage lives in the parent. Flush clears all state and
// overrides any push or pop offered in the same cycle.
module fifo_ptr_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_req_i,
  input  logic                       pop_req_i,
  output logic                       push_o,
  output logic                       pop_o,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr_o,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  logic full, empty, push, pop;

  // Status flags and qualified transfers from registered state only
  always_comb begin
    full  = (cnt_q == CNT_W'(DEPTH));
    empty = (cnt_q == '0);
    push  = push_req_i && !full  && !flush_i;
    pop   = pop_req_i  && !empty && !flush_i;
  end

  // Next-state for pointers and occupancy; pointers wrap by truncation
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Drive outputs
  always_comb begin
    push_o   = push;
    pop_o    = pop;
    wr_ptr_o = tail_q;
    rd_ptr_o = head_q;
    full_o   = full;
    empty_o  = empty;
    count_o  = cnt_q;
  end

endmodule : fifo_ptr_ctrl

// File: rtl/eu_result_buffer.sv
// Result staging FIFO between one execution unit and its CDB lane.
// Head entry is held stable on the CDB until granted or flushed; readiness
// depends only on registered occupancy, never on the CDB grant.
module eu_result_buffer
  import expipe_pkg::*;
#(
  parameter int unsigned DEPTH = EU_RES_BUF_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       eu_valid_i,
  output logic                       eu_ready_o,
  input  cdb_data_t                  eu_data_i,
  output logic                       cdb_valid_o,
  input  logic                       cdb_ready_i,
  output cdb_data_t                  cdb_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  cdb_data_t        mem_q [DEPTH];
  logic             wr_en, rd_en;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, empty;

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .push_req_i (eu_valid_i),
    .pop_req_i  (cdb_ready_i),
    .push_o     (wr_en),
    .pop_o      (rd_en),
    .wr_ptr_o   (wr_ptr),
    .rd_ptr_o   (rd_ptr),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count_o)
  );

  // Entry storage; deliberately not reset or cleared on flush
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr] <= eu_data_i;
  end

  // Handshake outputs and combinational head read
  always_comb begin
    eu_ready_o  = !full;
    cdb_valid_o = !empty;
    cdb_data_o  = mem_q[rd_ptr];
  end

  // Pop qualification is internal to the pointer controller
  logic unused_rd_en;
  always_comb unused_rd_en = rd_en;

endmodule : eu_result_buffer
